// File: rtl/branch_resolve_predictor.sv
`default_nettype none
// ============================================================================
//  Module   : branch_resolve_predictor
//  Purpose  : B-type branch resolution, misprediction flagging, 2-bit counter
//             direction predictor and saturating branch statistics.
//  Revision : 1.0
// ============================================================================
module branch_resolve_predictor #(
   parameter int IDX_W = 4,
   parameter int CNT_W = 32
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [31:0]      fetch_pc_i,
   output logic             pred_taken_o,
   input  logic             valid_i,
   input  logic             is_branch_i,
   input  logic [2:0]       funct3_i,
   input  logic [31:0]      pc_i,
   input  logic             pred_i,
   input  logic             br_eq_i,
   input  logic             br_lt_i,
   output logic             br_unsign_o,
   output logic             taken_o,
   output logic             mispredict_o,
   output logic             illegal_o,
   input  logic             clear_stats_i,
   output logic [CNT_W-1:0] branch_cnt_o,
   output logic [CNT_W-1:0] taken_cnt_o,
   output logic [CNT_W-1:0] mispred_cnt_o
);

   localparam int         c_ENTRIES  = 1 << IDX_W;
   localparam logic [1:0] c_STRONG_NT = 2'b00;
   localparam logic [1:0] c_WEAK_NT   = 2'b01;
   localparam logic [1:0] c_STRONG_T  = 2'b11;

   logic [1:0]       r_table [c_ENTRIES];
   logic [IDX_W-1:0] w_fetch_idx;
   logic [IDX_W-1:0] w_upd_idx;
   logic [1:0]       w_cnt_cur;
   logic [1:0]       w_cnt_nxt;
   logic             w_reserved;
   logic             w_res;
   logic             w_dir;
   logic [CNT_W-1:0] r_branch_cnt;
   logic [CNT_W-1:0] r_taken_cnt;
   logic [CNT_W-1:0] r_mispred_cnt;
   logic             w_unused_pc_bits;

   // PC bits outside the table index only alias entries together.
   assign w_unused_pc_bits = ^{fetch_pc_i[31:IDX_W+2], fetch_pc_i[1:0],
                               pc_i[31:IDX_W+2], pc_i[1:0]};

   assign w_fetch_idx  = fetch_pc_i[IDX_W+1:2];
   assign w_upd_idx    = pc_i[IDX_W+1:2];
   assign pred_taken_o = r_table[w_fetch_idx][1];

   // ------------------------------------------------------------------------
   // Resolution
   // ------------------------------------------------------------------------
   assign br_unsign_o = funct3_i[1];
   assign w_reserved  = (funct3_i == 3'b010) || (funct3_i == 3'b011);
   assign illegal_o   = valid_i & is_branch_i & w_reserved;
   assign w_res       = valid_i & is_branch_i & ~w_reserved;

   always_comb begin
      w_dir = 1'b0;
      case (funct3_i)
         3'b000:         w_dir = br_eq_i;
         3'b001:         w_dir = ~br_eq_i;
         3'b100, 3'b110: w_dir = br_lt_i;
         3'b101, 3'b111: w_dir = ~br_lt_i;
         default:        w_dir = 1'b0;
      endcase
   end

   assign taken_o      = w_res & w_dir;
   assign mispredict_o = w_res & (taken_o != pred_i);

   // ------------------------------------------------------------------------
   // Prediction table
   // ------------------------------------------------------------------------
   assign w_cnt_cur = r_table[w_upd_idx];

   always_comb begin
      w_cnt_nxt = w_cnt_cur;
      if (taken_o) begin
         if (w_cnt_cur != c_STRONG_T)
            w_cnt_nxt = w_cnt_cur + 2'b01;
      end else begin
         if (w_cnt_cur != c_STRONG_NT)
            w_cnt_nxt = w_cnt_cur - 2'b01;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < c_ENTRIES; i++)
            r_table[i] <= c_WEAK_NT;
      end else if (w_res) begin
         r_table[w_upd_idx] <= w_cnt_nxt;
      end
   end

   // ------------------------------------------------------------------------
   // Statistics: saturate at all-ones, clear has priority over counting
   // ------------------------------------------------------------------------
   function automatic logic [CNT_W-1:0] f_sat_inc(input logic [CNT_W-1:0] v);
      return (&v) ? v : v + CNT_W'(1);
   endfunction

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_branch_cnt  <= '0;
         r_taken_cnt   <= '0;
         r_mispred_cnt <= '0;
      end else if (clear_stats_i) begin
         r_branch_cnt  <= '0;
         r_taken_cnt   <= '0;
         r_mispred_cnt <= '0;
      end else if (w_res) begin
         r_branch_cnt <= f_sat_inc(r_branch_cnt);
         if (taken_o)
            r_taken_cnt <= f_sat_inc(r_taken_cnt);
         if (mispredict_o)
            r_mispred_cnt <= f_sat_inc(r_mispred_cnt);
      end
   end

   assign branch_cnt_o  = r_branch_cnt;
   assign taken_cnt_o   = r_taken_cnt;
   assign mispred_cnt_o = r_mispred_cnt;

endmodule
`default_nettype wire

// File: tb/tb_branch_resolve_predictor.sv
`default_nettype none
// ============================================================================
//  Module   : tb_branch_resolve_predictor
//  Purpose  : Self-checking bench for branch_resolve_predictor (32- and 4-bit
//             counter instances driven in parallel).
//  Revision : 1.0
// ============================================================================
module tb_branch_resolve_predictor;

   logic        clk;
   logic        rst_n;
   logic [31:0] fetch_pc, pc;
   logic        valid, is_branch, pred, br_eq, br_lt, clear;
   logic [2:0]  funct3;
   logic        pred_taken, br_unsign, taken, mispredict, illegal;
   logic [31:0] bcnt, tcnt, mcnt;
   logic        pred_taken_s, br_unsign_s, taken_s, mispredict_s, illegal_s;
   logic [3:0]  bcnt_s, tcnt_s, mcnt_s;

   int checks   = 0;
   int failures = 0;

   branch_resolve_predictor #(.IDX_W(4), .CNT_W(32)) dut (
      .clk(clk), .rst_n(rst_n), .fetch_pc_i(fetch_pc), .pred_taken_o(pred_taken),
      .valid_i(valid), .is_branch_i(is_branch), .funct3_i(funct3), .pc_i(pc),
      .pred_i(pred), .br_eq_i(br_eq), .br_lt_i(br_lt), .br_unsign_o(br_unsign),
      .taken_o(taken), .mispredict_o(mispredict), .illegal_o(illegal),
      .clear_stats_i(clear), .branch_cnt_o(bcnt), .taken_cnt_o(tcnt),
      .mispred_cnt_o(mcnt));

   branch_resolve_predictor #(.IDX_W(4), .CNT_W(4)) dut_s (
      .clk(clk), .rst_n(rst_n), .fetch_pc_i(fetch_pc), .pred_taken_o(pred_taken_s),
      .valid_i(valid), .is_branch_i(is_branch), .funct3_i(funct3), .pc_i(pc),
      .pred_i(pred), .br_eq_i(br_eq), .br_lt_i(br_lt), .br_unsign_o(br_unsign_s),
      .taken_o(taken_s), .mispredict_o(mispredict_s), .illegal_o(illegal_s),
      .clear_stats_i(clear), .branch_cnt_o(bcnt_s), .taken_cnt_o(tcnt_s),
      .mispred_cnt_o(mcnt_s));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #1ms;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1);
   end

   // Reference model: counter state 0..3 per entry, unbounded event counts
   int     m_tbl [16];
   longint n_br, n_tk, n_mp;
   bit     e_res, e_tk, e_mp, e_ill;
   int     e_fidx, e_uidx;

   typedef struct {
      logic       v, b;
      logic [2:0] f;
      logic       eq, lt;
      logic       t, il, u;
   } vec_t;
   vec_t vecs [16];

   task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0d expected %0d", nm, act, exp);
      end
   endtask

   function automatic longint f_sat(input longint n, input longint mx);
      return (n > mx) ? mx : n;
   endfunction

   function automatic bit f_dir(input logic [2:0] f, input logic eq, input logic lt);
      case (f)
         3'd0:       return eq;
         3'd1:       return !eq;
         3'd4, 3'd6: return lt;
         3'd5, 3'd7: return !lt;
         default:    return 1'b0;
      endcase
   endfunction

   task automatic model_reset();
      for (int i = 0; i < 16; i++) m_tbl[i] = 1;
      n_br = 0; n_tk = 0; n_mp = 0;
   endtask

   task automatic step_check();
      #2;
      e_ill  = valid && is_branch && (funct3 == 3'd2 || funct3 == 3'd3);
      e_res  = valid && is_branch && !e_ill;
      e_tk   = e_res && f_dir(funct3, br_eq, br_lt);
      e_mp   = e_res && (e_tk != pred);
      e_fidx = int'((fetch_pc / 4) % 16);
      e_uidx = int'((pc / 4) % 16);
      check("illegal",    illegal,    e_ill);
      check("taken",      taken,      e_tk);
      check("mispredict", mispredict, e_mp);
      check("br_unsign",  br_unsign,  (funct3 == 3'd6 || funct3 == 3'd7 ||
                                       funct3 == 3'd2 || funct3 == 3'd3));
      check("pred_taken", pred_taken, m_tbl[e_fidx] >= 2);
      check("branch_cnt", bcnt,   f_sat(n_br, 64'hFFFF_FFFF));
      check("taken_cnt",  tcnt,   f_sat(n_tk, 64'hFFFF_FFFF));
      check("mispred_cnt", mcnt,  f_sat(n_mp, 64'hFFFF_FFFF));
      check("branch_cnt4", bcnt_s, f_sat(n_br, 15));
      check("taken_cnt4",  tcnt_s, f_sat(n_tk, 15));
      check("mispred_cnt4", mcnt_s, f_sat(n_mp, 15));
   endtask

   task automatic step_clock();
      @(posedge clk);
      if (e_res) begin
         if (e_tk) m_tbl[e_uidx] = (m_tbl[e_uidx] == 3) ? 3 : m_tbl[e_uidx] + 1;
         else      m_tbl[e_uidx] = (m_tbl[e_uidx] == 0) ? 0 : m_tbl[e_uidx] - 1;
      end
      if (clear) begin
         n_br = 0; n_tk = 0; n_mp = 0;
      end else if (e_res) begin
         n_br++;
         if (e_tk) n_tk++;
         if (e_mp) n_mp++;
      end
      #1;
   endtask

   task automatic step();
      step_check();
      step_clock();
   endtask

   task automatic set_br(input logic [2:0] f, input logic eq, input logic lt,
                         input logic p, input logic [31:0] upc);
      valid = 1'b1; is_branch = 1'b1; funct3 = f;
      br_eq = eq; br_lt = lt; pred = p; pc = upc;
   endtask

   // Asynchronous reset mid-cycle while a resolve event is being presented
   task automatic do_reset_mid();
      set_br(3'd0, 1'b1, 1'b0, 1'b0, 32'h0000_0010);
      clear = 1'b0;
      #2 rst_n = 1'b0;
      #1;
      check("rst_bcnt", bcnt, 0);   check("rst_tcnt", tcnt, 0);
      check("rst_mcnt", mcnt, 0);   check("rst_bcnt4", bcnt_s, 0);
      for (int i = 0; i < 16; i++) begin
         fetch_pc = ($urandom() << 6) | 32'(i << 2);
         #1 check("rst_pred", pred_taken, 0);
      end
      model_reset();
      valid = 1'b0;
      @(posedge clk);
      #3 rst_n = 1'b1;
      @(posedge clk);
      #1;
   endtask

   initial begin
      rst_n = 1'b0; fetch_pc = '0; pc = '0; valid = 0; is_branch = 0;
      funct3 = '0; pred = 0; br_eq = 0; br_lt = 0; clear = 0;
      model_reset();
      repeat (2) @(posedge clk);
      #3 rst_n = 1'b1;
      @(posedge clk);
      #1;
      step();

      //                v     b     f       eq    lt    t     il    u
      vecs[0]  = '{1'b1, 1'b1, 3'd0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
      vecs[1]  = '{1'b1, 1'b1, 3'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
      vecs[2]  = '{1'b1, 1'b1, 3'd1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
      vecs[3]  = '{1'b1, 1'b1, 3'd1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
      vecs[4]  = '{1'b1, 1'b1, 3'd4, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
      vecs[5]  = '{1'b1, 1'b1, 3'd4, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
      vecs[6]  = '{1'b1, 1'b1, 3'd5, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
      vecs[7]  = '{1'b1, 1'b1, 3'd5, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
      vecs[8]  = '{1'b1, 1'b1, 3'd6, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
      vecs[9]  = '{1'b1, 1'b1, 3'd7, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
      vecs[10] = '{1'b1, 1'b1, 3'd7, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
      vecs[11] = '{1'b1, 1'b1, 3'd2, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1};
      vecs[12] = '{1'b1, 1'b1, 3'd3, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
      vecs[13] = '{1'b0, 1'b1, 3'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
      vecs[14] = '{1'b1, 1'b0, 3'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
      vecs[15] = '{1'b0, 1'b1, 3'd2, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};

      for (int i = 0; i < 16; i++) begin
         valid = vecs[i].v; is_branch = vecs[i].b; funct3 = vecs[i].f;
         br_eq = vecs[i].eq; br_lt = vecs[i].lt; pred = 1'b0;
         pc = $urandom(); fetch_pc = $urandom();
         step_check();
         check("vec_taken",   taken,      vecs[i].t);
         check("vec_illegal", illegal,    vecs[i].il);
         check("vec_unsign",  br_unsign,  vecs[i].u);
         check("vec_mispred", mispredict, vecs[i].t);
         step_clock();
      end

      for (int i = 0; i < 400; i++) begin
         valid = $urandom_range(0, 3) != 0; is_branch = $urandom_range(0, 4) != 0;
         funct3 = 3'($urandom()); br_eq = 1'($urandom()); br_lt = 1'($urandom());
         pred = 1'($urandom()); pc = $urandom(); fetch_pc = $urandom();
         clear = $urandom_range(0, 40) == 0;
         step();
      end
      clear = 1'b0;

      do_reset_mid();
      set_br(3'd0, 1'b1, 1'b0, 1'b0, 32'h0000_0104);
      step();
      check("first_res_bcnt", bcnt, 1);

      // Saturation on entry 0 via pc 0x40
      fetch_pc = 32'h40;
      set_br(3'd0, 1'b1, 1'b0, 1'b1, 32'h40);
      step_check();
      check("sat_pred_before", pred_taken, 0);
      step_clock();
      check("sat_pred_after1", pred_taken, 1);
      repeat (3) step();
      br_eq = 1'b0;
      step();
      check("sat_nt_pred", pred_taken, 1);

      // Same index read/write: entry 0 at 10, not-taken moves it to 01
      fetch_pc = 32'h80;
      set_br(3'd0, 1'b0, 1'b0, 1'b1, 32'hC0);
      step_check();
      check("same_idx_old", pred_taken, 1);
      step_clock();
      check("same_idx_new", pred_taken, 0);

      valid = 1'b0; clear = 1'b1;
      step();
      clear = 1'b0;
      for (int k = 0; k < 10; k++) begin
         set_br(3'd0, (k % 2) == 0, 1'b0, 1'b1, $urandom());
         step_check();
         check("mp_pulse", mispredict, (k % 2) != 0);
         step_clock();
      end
      check("mp_bcnt", bcnt, 10); check("mp_tcnt", tcnt, 5); check("mp_mcnt", mcnt, 5);

      set_br(3'd1, 1'b0, 1'b0, 1'b0, 32'h8);
      clear = 1'b1;
      step();
      clear = 1'b0;
      check("clr_bcnt", bcnt, 0); check("clr_tcnt", tcnt, 0); check("clr_mcnt", mcnt, 0);

      set_br(3'd0, 1'b1, 1'b0, 1'b0, 32'h24);
      repeat (20) step();
      check("sat4_bcnt", bcnt_s, 15);
      check("sat4_tcnt", tcnt_s, 15);
      check("sat32_bcnt", bcnt, 20);

      valid = 1'b0;
      step();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/branch_resolve_predictor.md
# branch_resolve_predictor

Branch resolution and prediction unit for the RISC-V core. It is the consumer of the branch comparator's BrEq/BrLt flags, and it also drives the comparator's signed/unsigned select from funct3. The unit decides branch direction for B-type instructions and flags mispredictions against the fetch-time guess. It holds a PC-indexed table of 2-bit saturating counters that supplies that guess, plus saturating performance counters. It sits between the execute stage and the PC-select mux.

## Interface

Parameters:
- IDX_W, 4, log2 of table entries (16 entries); index = pc[IDX_W+1:2]
- CNT_W, 32, width of each performance counter

Ports:
- clk  input  1  core clock
- rst_n  input  1  reset, asynchronous, active-low
- fetch_pc_i  input  32  PC being fetched; selects the table entry for prediction
- pred_taken_o  output  1  prediction for fetch_pc_i = MSB of selected counter (combinational)
- valid_i  input  1  execute-stage instruction valid
- is_branch_i  input  1  execute-stage instruction is B-type (opcode 1100011)
- funct3_i  input  3  branch funct3
- pc_i  input  32  execute-stage branch PC; selects the table entry to update
- pred_i  input  1  prediction made for this instruction at fetch (carried down the pipe)
- br_eq_i  input  1  BrEq from comparator
- br_lt_i  input  1  BrLt from comparator
- br_unsign_o  output  1  comparator unsigned select = funct3_i[1] (combinational)
- taken_o  output  1  resolved direction (combinational)
- mispredict_o  output  1  resolved direction differs from pred_i (combinational)
- illegal_o  output  1  valid branch with reserved funct3 010/011 (combinational)
- clear_stats_i  input  1  synchronous clear of the performance counters
- branch_cnt_o  output  CNT_W  resolved legal branches
- taken_cnt_o  output  CNT_W  resolved taken branches
- mispred_cnt_o  output  CNT_W  mispredictions

## Operation

- Resolve event (res) = valid_i & is_branch_i & ~illegal_o.
- Direction for res:
  - BEQ 000 → eq
  - BNE 001 → ~eq
  - BLT 100 / BLTU 110 → lt
  - BGE 101 / BGEU 111 → ~lt
- taken_o = 0 whenever there is no res.
- illegal_o = valid_i & is_branch_i & (funct3_i == 010 or 011).
- An illegal branch forces taken_o = 0, mispredict_o = 0, no table update and no counter change.
- mispredict_o = res & (taken_o != pred_i).
- Table update on res: the entry at pc_i[IDX_W+1:2] saturating-increments if taken, saturating-decrements if not.
  - States: 00 strong NT, 01 weak NT, 10 weak T, 11 strong T.
  - 11 + taken stays 11; 00 + not-taken stays 00.
- Counters on res:
  - branch_cnt always +1.
  - taken_cnt +1 if taken_o.
  - mispred_cnt +1 if mispredict_o.
  - Each counter saturates at all-ones and never wraps.
- clear_stats_i zeroes all three counters. When it coincides with res, the clear wins (counters read 0 next cycle). The table is unaffected by clear_stats_i.

## Timing

- All outputs except the counters are combinational, with zero latency; br_unsign_o must settle before the comparator flags are used.
- Table and counter updates take effect at the rising clk edge after res; they are visible on outputs from the next cycle.
- Read/write of the same index in the same cycle (fetch_pc_i and pc_i map to the same entry): pred_taken_o returns the pre-update value, with no bypass.
- Aliasing: PCs differing only above bit IDX_W+1 share an entry. This is by design.
- Reset (rst_n low, any time, including mid-update):
  - All table entries go to 01 immediately.
  - All counters go to 0.
  - pred_taken_o = 0.
  - Combinational outputs follow their inputs.
  - No partial update survives reset.
- First edge after rst_n rises performs normal updates.

## Test plan

- **Reset:** assert rst_n=0 mid-run with counters nonzero.
  - Expect all counters 0 and pred_taken_o=0 for every fetch_pc_i.
  - First res after release counts as branch_cnt=1.
- **All six funct3 codes:** sweep eq/lt combinations.
  - BEQ eq=1 → taken 1; BNE eq=1 → 0; BLT lt=1 → 1; BGE lt=1 → 0.
  - BLTU/BGEU give br_unsign_o=1; BEQ/BNE/BLT/BGE give 0.
  - funct3 010 with valid → illegal_o=1, taken_o=0, counters unchanged.
- **Saturation:** 4 taken branches at pc 0x40.
  - Entry path 01→10→11→11.
  - pred_taken_o for fetch_pc 0x40 is 0 before the first edge, 1 after the first.
  - Then 1 not-taken → 10, still predicting taken.
- **Misprediction count:** 10 branches with pred_i=1 and taken alternating 1,0.
  - mispredict_o pulses on the 5 not-taken branches.
  - Result: mispred_cnt=5, taken_cnt=5, branch_cnt=10.
- **Same-index read/write:** fetch_pc_i=0x80 and pc_i=0xC0 (index 0) in the same cycle.
  - pred_taken_o shows the old value; the new value appears next cycle.
- **Clear collision and counter saturation:** clear_stats_i together with res → all counters 0.
  - With CNT_W=4, 20 res events → branch_cnt holds at 15.
